// File: rtl/mtr_pwm_drv_if.sv
// ============================================================================
// Module   : mtr_pwm_drv_if
// Brief    : Speed-command / drive-output bundle of the motor PWM driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mtr_pwm_drv_if;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               shtdwn;
  logic               lft_pwm1;
  logic               lft_pwm2;
  logic               rght_pwm1;
  logic               rght_pwm2;
  logic               pwm_synch;
  logic               fault;

  // Controller side: issues speed commands and shutdown, observes drives.
  modport master (
    output lft_spd, rght_spd, shtdwn,
    input  lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_synch, fault
  );

  // Driver side.
  modport slave (
    input  lft_spd, rght_spd, shtdwn,
    output lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_synch, fault
  );
endinterface

`default_nettype wire

// File: rtl/mtr_pwm_drv.sv
// ============================================================================
// Module   : mtr_pwm_drv
// Brief    : Dual-side motor PWM driver. Shared 2048-clock period counter,
//            period-aligned duty reload, dead-time insertion between the
//            complementary drives and a latched shutdown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtr_pwm_drv #(
  parameter int NONOVERLAP = 32
) (
  input  logic         clk,
  input  logic         rst,
  mtr_pwm_drv_if.slave bus
);

  // Run counter only has to reach NONOVERLAP (max 255), then it saturates.
  localparam int                 C_RUN_W    = 8;
  localparam logic [C_RUN_W-1:0] C_RUN_MAX  = C_RUN_W'(NONOVERLAP);
  localparam logic [C_RUN_W-1:0] C_RUN_ONE  = C_RUN_W'(1);
  localparam logic [10:0]        C_CNT_LAST = 11'd2047;
  localparam logic [10:0]        C_DUTY_MID = 11'd1024;

  logic [10:0]        r_cnt;
  logic               r_synch;
  logic               r_fault;
  logic               w_wrap;
  logic               w_kill;
  logic signed [11:0] w_spd [2];

  assign w_wrap   = (r_cnt == C_CNT_LAST);
  // A shutdown request gates the drives on the very edge it is sampled.
  assign w_kill   = r_fault | bus.shtdwn;
  assign w_spd[0] = bus.lft_spd;
  assign w_spd[1] = bus.rght_spd;

  // Free-running period counter, period-boundary strobe and shutdown latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_synch <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 11'd1;
      r_synch <= (r_cnt == 11'd0);
      r_fault <= w_kill;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic signed [10:0] w_sat;
    logic [10:0]        w_duty_nxt;
    logic [10:0]        r_duty;
    logic               w_raw;
    logic               w_same;
    logic               w_settled;
    logic               r_prev;
    logic [C_RUN_W-1:0] r_run;
    logic               r_pwm1;
    logic               r_pwm2;

    // Clamp the 12-bit command into the 11-bit signed range.
    always_comb begin
      w_sat = w_spd[gi][10:0];
      if (w_spd[gi] > 12'sd1023) begin
        w_sat = 11'sh3FF;
      end else if (w_spd[gi] < -12'sd1024) begin
        w_sat = 11'sh400;
      end
    end

    // Adding 1024 to an 11-bit two's-complement value is an MSB flip.
    assign w_duty_nxt = {~w_sat[10], w_sat[9:0]};
    assign w_raw      = (r_cnt < r_duty);
    // r_run counts consecutive past cycles at level r_prev; zero means no
    // history yet (after reset), so the dead-time restarts from scratch.
    assign w_same     = (r_run != '0) && (w_raw == r_prev);
    assign w_settled  = w_same && (r_run >= C_RUN_MAX);

    // Duty reload at period end, dead-time tracking and gated drive outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_duty <= C_DUTY_MID;
        r_prev <= 1'b0;
        r_run  <= '0;
        r_pwm1 <= 1'b0;
        r_pwm2 <= 1'b0;
      end else begin
        if (w_wrap) begin
          r_duty <= w_duty_nxt;
        end
        r_prev <= w_raw;
        if (!w_same) begin
          r_run <= C_RUN_ONE;
        end else if (r_run != C_RUN_MAX) begin
          r_run <= r_run + C_RUN_ONE;
        end
        r_pwm1 <= w_settled &  w_raw & ~w_kill;
        r_pwm2 <= w_settled & ~w_raw & ~w_kill;
      end
    end
  end

  assign bus.lft_pwm1  = g_side[0].r_pwm1;
  assign bus.lft_pwm2  = g_side[0].r_pwm2;
  assign bus.rght_pwm1 = g_side[1].r_pwm1;
  assign bus.rght_pwm2 = g_side[1].r_pwm2;
  assign bus.pwm_synch = r_synch;
  assign bus.fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mtr_pwm_drv.sv
// ============================================================================
// Module   : tb_mtr_pwm_drv
// Brief    : Self-checking bench for mtr_pwm_drv with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtr_pwm_drv;
  localparam int NONOVERLAP = 32;
  localparam int PERIOD     = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mtr_pwm_drv_if bus ();

  mtr_pwm_drv #(.NONOVERLAP(NONOVERLAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: period position, duties, fault latch and the
  // recent raw history of each side (newest at the back).
  int m_cnt = 0;
  int m_duty [2];
  bit m_fault = 1'b0;
  bit hist [2][$];
  bit e_pwm1 [2];
  bit e_pwm2 [2];
  bit e_synch = 1'b0;
  bit e_fault = 1'b0;

  // Observed high-cycle tallies over a measurement window.
  int a_l1, a_l2, a_r1, a_r2, a_sy;

  logic [11:0] pats [7] = '{12'h7FF, 12'h800, 12'h3FF, 12'hC00,
                            12'h400, 12'hBFF, 12'h000};

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int sat_duty(input logic [11:0] spd);
    int v;
    v = int'($signed(spd));
    if (v > 1023)  v = 1023;
    if (v < -1024) v = -1024;
    return v + 1024;
  endfunction

  function automatic logic [11:0] pick();
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 7) return 12'($urandom);
    return pats[k];
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    logic [11:0] spd [2];
    bit raw, all1, all0, kill;
    spd[0] = bus.lft_spd;
    spd[1] = bus.rght_spd;
    if (rst) begin
      m_cnt   = 0;
      m_fault = 1'b0;
      e_synch = 1'b0;
      e_fault = 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_duty[s] = 1024;
        hist[s].delete();
        e_pwm1[s] = 1'b0;
        e_pwm2[s] = 1'b0;
      end
    end else begin
      e_synch = (m_cnt == 0);
      kill    = m_fault || bus.shtdwn;
      for (int s = 0; s < 2; s++) begin
        raw = (m_cnt < m_duty[s]);
        hist[s].push_back(raw);
        if (hist[s].size() > NONOVERLAP + 1) void'(hist[s].pop_front());
        all1 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < hist[s].size(); k++) begin
          if (hist[s][k]) all0 = 1'b0;
          else            all1 = 1'b0;
        end
        e_pwm1[s] = !kill && (hist[s].size() == NONOVERLAP + 1) && all1;
        e_pwm2[s] = !kill && (hist[s].size() == NONOVERLAP + 1) && all0;
      end
      if (bus.shtdwn) m_fault = 1'b1;
      e_fault = m_fault;
      if (m_cnt == PERIOD - 1) begin
        m_duty[0] = sat_duty(spd[0]);
        m_duty[1] = sat_duty(spd[1]);
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  // One clock: update model at the edge, compare every output 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("lft_pwm1",  bus.lft_pwm1,  e_pwm1[0]);
    check("lft_pwm2",  bus.lft_pwm2,  e_pwm2[0]);
    check("rght_pwm1", bus.rght_pwm1, e_pwm1[1]);
    check("rght_pwm2", bus.rght_pwm2, e_pwm2[1]);
    check("pwm_synch", bus.pwm_synch, e_synch);
    check("fault",     bus.fault,     e_fault);
    check("lft_overlap",  bus.lft_pwm1  & bus.lft_pwm2,  0);
    check("rght_overlap", bus.rght_pwm1 & bus.rght_pwm2, 0);
    a_l1 += int'(bus.lft_pwm1);
    a_l2 += int'(bus.lft_pwm2);
    a_r1 += int'(bus.rght_pwm1);
    a_r2 += int'(bus.rght_pwm2);
    a_sy += int'(bus.pwm_synch);
  endtask

  task automatic wait_cnt(input int c);
    int g;
    g = 0;
    while (m_cnt != c && g < 2 * PERIOD) begin
      step();
      g++;
    end
    if (m_cnt != c) begin
      n_errors++;
      $display("FAIL wait_cnt: reached %0d required %0d", m_cnt, c);
    end
  endtask

  // Measure one aligned period; optionally change lft_spd at count chg_at.
  task automatic run_period(input int chg_at, input logic [11:0] new_l);
    wait_cnt(0);
    a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; a_sy = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (m_cnt == chg_at) bus.lft_spd = new_l;
      step();
    end
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.lft_spd  = '0;
    bus.rght_spd = '0;
    bus.shtdwn   = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Zero speed: 992-clock drives on both phases, one synch per period.
    run_period(-1, '0);
    run_period(-1, '0);
    check("s1_l1_len", a_l1, 992);
    check("s1_l2_len", a_l2, 992);
    check("s1_r1_len", a_r1, 992);
    check("s1_synch",  a_sy, 1);

    // Saturating extremes.
    bus.lft_spd  = 12'h7FF;
    bus.rght_spd = 12'h800;
    run_period(-1, '0);
    run_period(-1, '0);
    check("s2_l1_len", a_l1, 2015);
    check("s2_l2_len", a_l2, 0);
    check("s2_r1_len", a_r1, 0);
    check("s2_r2_len", a_r2, 2048);

    // Mid-period speed change only takes effect next period.
    bus.lft_spd  = '0;
    bus.rght_spd = '0;
    run_period(-1, '0);
    run_period(500, 12'd400);
    check("s3_l1_same", a_l1, 992);
    run_period(-1, '0);
    check("s3_l1_next", a_l1, 1392);
    check("s3_l2_next", a_l2, 592);

    // Reset mid-pulse at cnt 1200.
    wait_cnt(1200);
    check("s5_l1_before", bus.lft_pwm1, 1);
    rst = 1'b1;
    step();
    check("s5_drv_off", {bus.lft_pwm1, bus.lft_pwm2, bus.rght_pwm1, bus.rght_pwm2}, 0);
    bus.lft_spd = '0;
    rst = 1'b0;
    step();
    check("s5_synch_first", bus.pwm_synch, 1);
    run_period(-1, '0);
    run_period(-1, '0);
    check("s5_l1_len", a_l1, 992);
    check("s5_l2_len", a_l2, 992);

    // Single-cycle shutdown pulse mid-period.
    wait_cnt(700);
    bus.shtdwn = 1'b1;
    step();
    bus.shtdwn = 1'b0;
    check("s4_fault", bus.fault, 1);
    check("s4_drv_off", {bus.lft_pwm1, bus.lft_pwm2, bus.rght_pwm1, bus.rght_pwm2}, 0);
    run_period(-1, '0);
    check("s4_drv_sum", a_l1 + a_l2 + a_r1 + a_r2, 0);
    check("s4_synch",   a_sy, 1);
    check("s4_fault_hold", bus.fault, 1);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    run_period(-1, '0);
    run_period(-1, '0);
    check("s4_l1_recover", a_l1, 992);
    check("s4_fault_clear", bus.fault, 0);

    // Randomised commands with occasional resets and one shutdown episode.
    for (int i = 0; i < 16000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 4)       bus.lft_spd  = pick();
      else if (r < 8)  bus.rght_spd = pick();
      else if (r == 8) rst = 1'b1;
      if (i == 9000) bus.shtdwn = 1'b1;
      if (i == 9600) rst = 1'b1;
      step();
      rst = 1'b0;
      bus.shtdwn = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
